// File: rtl/read_data_merger.sv
// R-channel merger: re-joins 4KB-split reads by suppressing the first half's RLAST and strips the master index from RID.
// Optional RDM_SKID_EN: registered 2-entry skid buffer; otherwise a zero-latency combinational pass-through.
module read_data_merger #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2,
  parameter int TID_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      s_axi_r_rdata,
  input  logic [IDX_W+TID_W-1:0] s_axi_r_rid,
  input  logic [1:0]             s_axi_r_rresp,
  input  logic                   s_axi_r_rlast,
  input  logic                   s_axi_r_valid,
  output logic                   s_axi_r_ready,
  input  logic [TID_W-1:0]       r_transactionid0,
  input  logic [TID_W-1:0]       r_transactionid1,
  input  logic [TID_W-1:0]       r_transactionid2,
  input  logic [2:0]             itemvalid,
  input  logic [2:0]             fkflag,
  output logic [DATA_W-1:0]      m_axi_r_rdata,
  output logic [TID_W-1:0]       m_axi_r_rid,
  output logic [1:0]             m_axi_r_rresp,
  output logic                   m_axi_r_rlast,
  output logic                   m_axi_r_valid,
  input  logic                   m_axi_r_ready,
  output logic [TID_W-1:0]       dec_fifo_r_rid,
  output logic                   dec_fifo_r_rlast,
  output logic                   dec_fifo_r_valid,
  output logic                   dec_fifo_r_ready,
  output logic                   dec_r_rlast,
  output logic                   dec_r_valid,
  output logic                   dec_r_ready,
  output logic                   merge_err
);

  localparam int NID    = 1 << TID_W;
  localparam int BEAT_W = DATA_W + TID_W + 3;

  logic [TID_W-1:0]  in_tid_s;
  logic              rid_idx_unused_s;
  logic              hit_s;
  logic              hit_fk_s;
  logic              suppress_s;
  logic              rlast_eff_s;
  logic              in_hs_s;
  logic [NID-1:0]    split_pending_q, split_pending_d;
  logic              merge_err_q, merge_err_d;
  logic [BEAT_W-1:0] in_beat_s;
  logic [BEAT_W-1:0] out_beat_s;

  assign in_tid_s         = s_axi_r_rid[TID_W-1:0];
  assign rid_idx_unused_s = ^s_axi_r_rid[TID_W +: IDX_W];
  assign in_hs_s          = s_axi_r_valid && s_axi_r_ready;

  // Item-table lookup: the lowest-numbered valid entry with a matching ID wins
  always_comb begin
    hit_s    = 1'b0;
    hit_fk_s = 1'b0;
    if (itemvalid[0] && (r_transactionid0 == in_tid_s)) begin
      hit_s    = 1'b1;
      hit_fk_s = fkflag[0];
    end else if (itemvalid[1] && (r_transactionid1 == in_tid_s)) begin
      hit_s    = 1'b1;
      hit_fk_s = fkflag[1];
    end else if (itemvalid[2] && (r_transactionid2 == in_tid_s)) begin
      hit_s    = 1'b1;
      hit_fk_s = fkflag[2];
    end else begin
      hit_s    = 1'b0;
      hit_fk_s = 1'b0;
    end
  end

  assign suppress_s  = s_axi_r_rlast && hit_s && hit_fk_s;
  assign rlast_eff_s = s_axi_r_rlast && !suppress_s;
  assign in_beat_s   = {s_axi_r_rdata, in_tid_s, s_axi_r_rresp, rlast_eff_s};

  // Per-ID split tracking; a second first-half on a pending ID flags a sequence error
  always_comb begin
    split_pending_d = split_pending_q;
    merge_err_d     = 1'b0;
    if (in_hs_s && s_axi_r_rlast) begin
      split_pending_d[in_tid_s] = suppress_s;
      merge_err_d               = suppress_s && split_pending_q[in_tid_s];
    end else begin
      merge_err_d = 1'b0;
    end
  end

  // Split-pending and error-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_pending_q <= {NID{1'b0}};
      merge_err_q     <= 1'b0;
    end else begin
      split_pending_q <= split_pending_d;
      merge_err_q     <= merge_err_d;
    end
  end

  assign merge_err = merge_err_q;

`ifdef RDM_SKID_EN
  logic [BEAT_W-1:0] out_q, out_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              rdy_q, rdy_d;
  logic              pop_s;

  assign pop_s = out_valid_q && m_axi_r_ready;

  // Skid steering: the skid entry always drains into the output entry first, preserving order
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (pop_s) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (in_hs_s) begin
      if (!out_valid_q || pop_s) begin
        out_d       = in_beat_s;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_beat_s;
        skid_valid_d = 1'b1;
      end
    end else if (pop_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    rdy_d = !skid_valid_d;
  end

  // Buffer storage and registered upstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= {BEAT_W{1'b0}};
      skid_q       <= {BEAT_W{1'b0}};
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign out_beat_s    = out_q;
  assign m_axi_r_valid = out_valid_q;
  assign s_axi_r_ready = rdy_q;
`else
  assign out_beat_s    = rst_n ? in_beat_s : {BEAT_W{1'b0}};
  assign m_axi_r_valid = s_axi_r_valid && rst_n;
  assign s_axi_r_ready = m_axi_r_ready && rst_n;
`endif

  assign {m_axi_r_rdata, m_axi_r_rid, m_axi_r_rresp, m_axi_r_rlast} = out_beat_s;

  assign dec_fifo_r_rid   = in_tid_s;
  assign dec_fifo_r_rlast = s_axi_r_rlast;
  assign dec_fifo_r_valid = s_axi_r_valid;
  assign dec_fifo_r_ready = s_axi_r_ready;
  assign dec_r_rlast      = m_axi_r_rlast;
  assign dec_r_valid      = m_axi_r_valid;
  assign dec_r_ready      = m_axi_r_ready;

endmodule
